// File: rtl/game_pkg.sv
// Shared types and constants for the game controller's sequence path.
package game_pkg;

  typedef enum logic {
    SG_IDLE = 1'b0,
    SG_FILL = 1'b1
  } sg_state_e;

  localparam logic [1:0] DIFF_EASY = 2'b01;
  localparam logic [1:0] DIFF_MED  = 2'b10;
  localparam logic [1:0] DIFF_HARD = 2'b11;

  localparam int SEQ_DEPTH = 32;
  localparam int SEQ_AW    = 5;
  localparam int DIGIT_W   = 4;

  // Difficulty 00 falls back to the easy range.
  function automatic logic [DIGIT_W-1:0] sg_digit(
    input logic [1:0]  diff,
    input logic [15:0] lfsr
  );
    logic [DIGIT_W-1:0] d;
    d = {2'b00, lfsr[1:0]};
    unique case (1'b1)
      (diff == DIFF_MED):  d = {1'b0, lfsr[2:0]};
      (diff == DIFF_HARD): d = (lfsr[3:0] <= 4'd9) ? lfsr[3:0]
                                                   : lfsr[3:0] - 4'd10;
      default:             d = {2'b00, lfsr[1:0]};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seq_generator_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic [15:0] State
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0],
              lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) lfsr_q <= SEED_EFF;
    else      lfsr_q <= lfsr_d;
  end

  assign State = lfsr_q;

endmodule

// File: rtl/seq_generator.sv
// Fills a 32-entry digit memory on GoGen and serves the
// controller's registered reads.
module seq_generator
  import game_pkg::*;
#(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          DEPTH = SEQ_DEPTH
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               GoGen,
  input  logic [1:0]         Diff,
  input  logic [SEQ_AW-1:0]  SeqAddr,
  output logic [DIGIT_W-1:0] RAMOutput,
  output logic               FinGen,
  output logic               Busy
);

  localparam logic [SEQ_AW-1:0] LAST = SEQ_AW'(DEPTH - 1);

  sg_state_e          state_q, state_d;
  logic [SEQ_AW-1:0]  wr_addr_q, wr_addr_d;
  logic [1:0]         diff_q, diff_d;
  logic               fin_q, fin_d;
  logic               busy_q, busy_d;
  logic [DIGIT_W-1:0] rd_q;
  logic               we;
  logic [DIGIT_W-1:0] digit;
  logic [15:0]        lfsr;

  logic [DIGIT_W-1:0] mem_q [DEPTH];

  lfsr16 #(
    .SEED (SEED)
  ) u_lfsr (
    .Clk   (Clk),
    .Rst   (Rst),
    .State (lfsr)
  );

  assign digit = sg_digit(diff_q, lfsr);

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    diff_d    = diff_q;
    fin_d     = fin_q;
    busy_d    = busy_q;
    we        = 1'b0;
    unique case (state_q)
      SG_IDLE: begin
        if (GoGen) begin
          diff_d    = Diff;
          wr_addr_d = '0;
          fin_d     = 1'b0;
          busy_d    = 1'b1;
          state_d   = SG_FILL;
        end
      end
      SG_FILL: begin
        // A new request restarts the fill from address 0.
        if (GoGen) begin
          diff_d    = Diff;
          wr_addr_d = '0;
        end else begin
          we        = 1'b1;
          wr_addr_d = wr_addr_q + 1'b1;
          if (wr_addr_q == LAST) begin
            fin_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = SG_IDLE;
          end
        end
      end
      default: state_d = SG_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= SG_IDLE;
      wr_addr_q <= '0;
      diff_q    <= DIFF_EASY;
      fin_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      diff_q    <= diff_d;
      fin_q     <= fin_d;
      busy_q    <= busy_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (we) mem_q[wr_addr_q] <= digit;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) rd_q <= '0;
    else      rd_q <= mem_q[SeqAddr];
  end

  assign RAMOutput = rd_q;
  assign FinGen    = fin_q;
  assign Busy      = busy_q;

endmodule
